int_ctrl_banked: RTL and testbench
==================================

// Module: int_ctrl_banked
// PURPOSE
//  Parametrised interrupt controller, successor to the fixed 32-bit enable-only interface.
//  Banked enable/mode/pending registers on the shared tri-state CPU data bus.
//  Edge/level source capture, fixed-priority arbitration, and a req/ack/done handshake to the core.
//  Sits between peripheral interrupt sources and the CPU interrupt entry logic.
// PARAMETERS
//  N_SRC     64            number of interrupt sources; multiple of DATA_W
//  DATA_W    32            bus/register width
//  ADDR_W    4             register address width; must hold 3*NB+1 words (NB = N_SRC/DATA_W)
//  EN_RST    {N_SRC{1'b1}} enable register reset value
//  MODE_RST  {N_SRC{1'b1}} mode reset value (1 = edge, 0 = level)
// PORTS
//  clk        in     1               system clock, rising edge
//  rst_n      in     1               async active-low reset
//  data_io    inout  DATA_W          shared CPU data bus
//  addr       in     ADDR_W          register word select
//  cs_en      in     1               chip select
//  wt_en      in     1               write strobe (needs cs_en)
//  rd_en      in     1               read strobe (needs cs_en)
//  src_i      in     N_SRC           interrupt sources, synchronous to clk
//  irq_req    out    1               interrupt request to core
//  irq_id     out    $clog2(N_SRC)   winning source index, valid while irq_req=1
//  irq_ack    in     1               core accepts request (1-cycle pulse)
//  irq_done   in     1               core finished handler (1-cycle pulse)
// BEHAVIOUR
//  Reset (async): en=EN_RST, mode=MODE_RST, pend=0, src_d=0, FSM=IDLE, irq_req=0, irq_id=0, data_io=Z.
//  Register map (word k = bank k, bits [DATA_W*k +: DATA_W]):
//   0..NB-1       EN    R/W
//   NB..2NB-1     PEND  R; write-1-to-clear, edge-mode bits only
//   2NB..3NB-1    MODE  R/W
//   3NB           STAT  R: {in_service, irq_req, irq_id}, zero-extended; writes ignored
//   other addr    read 0; writes ignored
//  Bus drive:
//   - data_io driven with read data only when cs_en & rd_en & !wt_en (combinational); else Z.
//   - Write commits at posedge when cs_en & wt_en.
//  Capture: src_d <= src_i each cycle.
//   - Edge bit: pend set at posedge where src_i=1 & src_d=0.
//   - Level bit: pend = src_i registered every cycle; W1C has no effect.
//   - Same-cycle set and clear (W1C or ack) on one bit: set wins.
//  Arbitration: cand = pend & en; winner = lowest set index.
//  FSM:
//   IDLE: cand!=0 -> REQ; irq_id<=winner, irq_req<=1.
//   REQ:  cand[irq_id]==0 (SW cleared or disabled) -> IDLE, irq_req<=0 (withdraw).
//         irq_ack -> SERV, irq_req<=0; pend[irq_id] cleared if edge mode.
//         Ack wins over withdraw in the same cycle.
//         irq_id frozen in REQ even if a lower index becomes pending.
//   SERV: irq_done -> IDLE; no new request while in SERV (in_service=1).
//   irq_ack outside REQ and irq_done outside SERV are ignored.
//  Latency: src_i rises before edge k -> pend at k -> irq_req=1 after edge k+1 (FSM idle, bit enabled).
//   Back-to-back: done at edge j -> IDLE -> next irq_req after edge j+1.
//  Reset mid-operation: immediate return to reset state; in-flight request dropped, no ack needed.
//  Mode write on a pending bit: bit keeps its value, then follows the new mode rules.
// TESTING
//  1. Reset, read EN0/EN1/MODE0 -> 0xFFFFFFFF; PEND0 and STAT -> 0; data_io Z when rd_en=0.
//  2. Pulse src_i[5] 1 cycle -> PEND0=0x20; irq_req=1, irq_id=5 two edges after rise;
//     ack -> PEND0=0, irq_req=0; done -> STAT=0.
//  3. src_i[3] and src_i[40] rise together -> irq_id=3; after ack+done -> irq_id=40 next request.
//  4. Write EN1=0, pulse src_i[33] -> PEND1=0x2 but irq_req stays 0; write EN1=0x2 -> irq_req=1, irq_id=33.
//  5. MODE0 bit7=0, hold src_i[7] high -> irq_req=1; W1C PEND0=0x80 -> bit stays 1;
//     ack then done with src high -> re-request; src low -> no request.
//  6. irq_req=1 for id 9, assert rst_n=0 mid-cycle -> irq_req=0, PEND=0 immediately;
//     separately: W1C of bit 9 in REQ -> withdraw to IDLE.

Source files
------------

// File: rtl/int_ctrl_banked.sv
// Banked interrupt controller: edge/level capture, fixed lowest-index priority,
// and a req/ack/done handshake to the core, configured over a shared tri-state bus.
module int_ctrl_banked #(
    parameter int                 N_SRC    = 64,
    parameter int                 DATA_W   = 32,
    parameter int                 ADDR_W   = 4,
    parameter logic [N_SRC-1:0]   EN_RST   = {N_SRC{1'b1}},
    parameter logic [N_SRC-1:0]   MODE_RST = {N_SRC{1'b1}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    inout  wire logic [DATA_W-1:0]     data_io,
    input  logic [ADDR_W-1:0]          addr,
    input  logic                       cs_en,
    input  logic                       wt_en,
    input  logic                       rd_en,
    input  logic [N_SRC-1:0]           src_i,
    output logic                       irq_req,
    output logic [$clog2(N_SRC)-1:0]   irq_id,
    input  logic                       irq_ack,
    input  logic                       irq_done
);

    // state  | meaning
    // S_IDLE | no request outstanding, arbitrating each cycle
    // S_REQ  | irq_req high, irq_id frozen, waiting for ack or withdraw
    // S_SERV | core is running the handler, waiting for done
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERV} state_t;

    localparam int NB  = N_SRC / DATA_W;
    localparam int IDW = $clog2(N_SRC);

    state_t             state_q;
    logic               irq_req_q;
    logic [IDW-1:0]     irq_id_q;
    logic [N_SRC-1:0]   en_q, en_d;
    logic [N_SRC-1:0]   mode_q, mode_d;
    logic [N_SRC-1:0]   pend_q, pend_d;
    logic [N_SRC-1:0]   src_q;
    logic [N_SRC-1:0]   w1c, ack_clr, clr, cand;
    logic [IDW-1:0]     winner;
    logic [DATA_W-1:0]  rd_data;
    logic               wr_stb;
    logic               rd_drv;

    assign wr_stb  = cs_en & wt_en;
    assign rd_drv  = cs_en & rd_en & ~wt_en;
    assign data_io = rd_drv ? rd_data : {DATA_W{1'bz}};
    assign cand    = pend_q & en_q;
    assign irq_req = irq_req_q;
    assign irq_id  = irq_id_q;

    always_comb begin
        en_d    = en_q;
        mode_d  = mode_q;
        w1c     = '0;
        ack_clr = '0;
        if (wr_stb) begin
            for (int b = 0; b < NB; b++) begin
                if (addr == ADDR_W'(b))        en_d[b*DATA_W +: DATA_W]   = data_io;
                if (addr == ADDR_W'(NB + b))   w1c[b*DATA_W +: DATA_W]    = data_io;
                if (addr == ADDR_W'(2*NB + b)) mode_d[b*DATA_W +: DATA_W] = data_io;
            end
        end
        if (state_q == S_REQ && irq_ack) ack_clr[irq_id_q] = 1'b1;
        // Clears only touch edge bits; a fresh edge in the same cycle still sets.
        clr    = (w1c | ack_clr) & mode_q;
        pend_d = (mode_q & ((pend_q & ~clr) | (src_i & ~src_q))) | (~mode_q & src_i);
    end

    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) winner = IDW'(i);
        end
    end

    always_comb begin
        rd_data = '0;
        for (int b = 0; b < NB; b++) begin
            if (addr == ADDR_W'(b))        rd_data = en_q[b*DATA_W +: DATA_W];
            if (addr == ADDR_W'(NB + b))   rd_data = pend_q[b*DATA_W +: DATA_W];
            if (addr == ADDR_W'(2*NB + b)) rd_data = mode_q[b*DATA_W +: DATA_W];
        end
        if (addr == ADDR_W'(3*NB)) rd_data = DATA_W'({state_q == S_SERV, irq_req_q, irq_id_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= EN_RST;
            mode_q <= MODE_RST;
            pend_q <= '0;
            src_q  <= '0;
        end else begin
            en_q   <= en_d;
            mode_q <= mode_d;
            pend_q <= pend_d;
            src_q  <= src_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            irq_req_q <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|cand) begin
                        state_q   <= S_REQ;
                        irq_req_q <= 1'b1;
                        irq_id_q  <= winner;
                    end
                end
                S_REQ: begin
                    // Ack takes precedence over a withdraw seen in the same cycle.
                    if (irq_ack) begin
                        state_q   <= S_SERV;
                        irq_req_q <= 1'b0;
                    end else if (!cand[irq_id_q]) begin
                        state_q   <= S_IDLE;
                        irq_req_q <= 1'b0;
                        irq_id_q  <= '0;
                    end
                end
                S_SERV: begin
                    if (irq_done) begin
                        state_q  <= S_IDLE;
                        irq_id_q <= '0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    irq_req_q <= 1'b0;
                    irq_id_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl_banked.sv
// Scoreboarded bench for int_ctrl_banked: directed scenarios, then random traffic
// checked against a per-cycle behavioural model of the controller.
module tb_int_ctrl_banked;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  addr = '0;
    logic        cs_en = 1'b0, wt_en = 1'b0, rd_en = 1'b0;
    logic [63:0] src_i = '0;
    logic        irq_ack = 1'b0, irq_done = 1'b0;
    logic        irq_req;
    logic [5:0]  irq_id;
    logic [31:0] tb_drv = '0;
    logic        tb_drv_en = 1'b0;
    wire  [31:0] data_io;

    assign data_io = tb_drv_en ? tb_drv : 32'bz;

    int_ctrl_banked dut (
        .clk(clk), .rst_n(rst_n), .data_io(data_io), .addr(addr),
        .cs_en(cs_en), .wt_en(wt_en), .rd_en(rd_en), .src_i(src_i),
        .irq_req(irq_req), .irq_id(irq_id), .irq_ack(irq_ack), .irq_done(irq_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_en, m_mode, m_pend, m_prev;
    int          m_phase;   // 0 idle, 1 requesting, 2 in service
    int          m_id;

    typedef struct { string name; logic [31:0] val; } rd_exp_t;
    rd_exp_t exp_rd[$];
    int      exp_irq[$];

    function automatic int lowest(input logic [63:0] v);
        for (int i = 0; i < 64; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_en = '1; m_mode = '1; m_pend = '0; m_prev = '0; m_phase = 0; m_id = 0;
    endtask

    function automatic logic [31:0] model_read(input int a);
        case (a)
            0, 1:    return m_en[a*32 +: 32];
            2, 3:    return m_pend[(a-2)*32 +: 32];
            4, 5:    return m_mode[(a-4)*32 +: 32];
            6:       return {24'd0, (m_phase == 2), (m_phase == 1), 6'(m_id)};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [63:0] cand, clr, np;
        int wa;
        cand = m_pend & m_en;
        clr  = '0;
        wa   = int'(addr);
        case (m_phase)
            0: if (cand != 0) begin
                   m_id = lowest(cand);
                   m_phase = 1;
                   exp_irq.push_back(m_id);
               end
            1: if (irq_ack) begin
                   m_phase = 2;
                   clr[m_id] = 1'b1;
               end else if (!cand[m_id]) begin
                   m_phase = 0;
                   m_id = 0;
               end
            default: if (irq_done) begin
                   m_phase = 0;
                   m_id = 0;
               end
        endcase
        if (cs_en && wt_en && (wa == 2 || wa == 3)) clr[(wa-2)*32 +: 32] = clr[(wa-2)*32 +: 32] | tb_drv;
        for (int i = 0; i < 64; i++) begin
            if (m_mode[i]) np[i] = (src_i[i] && !m_prev[i]) || (m_pend[i] && !clr[i]);
            else           np[i] = src_i[i];
        end
        if (cs_en && wt_en) begin
            if (wa == 0 || wa == 1) m_en[wa*32 +: 32] = tb_drv;
            if (wa == 4 || wa == 5) m_mode[(wa-4)*32 +: 32] = tb_drv;
        end
        m_pend = np;
        m_prev = src_i;
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- monitor ----------------
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0;
        end else begin
            chk("irq_req_level", 64'(irq_req), 64'(m_phase == 1));
            if (irq_req && !prev_req) begin
                if (exp_irq.size() == 0) chk("irq_unexpected", 64'(irq_id), 64'hFFFF);
                else chk("irq_id_on_req", 64'(irq_id), 64'(exp_irq.pop_front()));
            end
            prev_req = irq_req;
            if (cs_en && rd_en && !wt_en) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", 64'(data_io), 64'hFFFF_FFFF_FFFF);
                else begin
                    rd_exp_t e;
                    e = exp_rd.pop_front();
                    chk(e.name, 64'(data_io), 64'(e.val));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cs_en = 1'b1; wt_en = 1'b1; addr = a; tb_drv = d; tb_drv_en = 1'b1;
        step();
        cs_en = 1'b0; wt_en = 1'b0; tb_drv_en = 1'b0;
    endtask

    task automatic rd_const(input logic [3:0] a, input logic [31:0] v, input string name);
        rd_exp_t e;
        e.name = name; e.val = v;
        cs_en = 1'b1; rd_en = 1'b1; addr = a;
        exp_rd.push_back(e);
        step();
        cs_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        irq_done = 1'b1; step(); irq_done = 1'b0;
    endtask

    initial begin
        logic zok;
        rd_exp_t e;
        // 1: reset values and bus release
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("rst_irq_req", 64'(irq_req), 0);
        chk("rst_irq_id", 64'(irq_id), 0);
        zok = (data_io === 32'bz);
        chk("bus_z_idle", 64'(zok), 1);
        cs_en = 1'b1; rd_en = 1'b1; wt_en = 1'b1; addr = 4'd7; #1;
        zok = (data_io === 32'bz);
        chk("bus_z_rd_wt", 64'(zok), 1);
        cs_en = 1'b0; rd_en = 1'b0; wt_en = 1'b0;
        rd_const(0, 32'hFFFF_FFFF, "rst_en0");
        rd_const(1, 32'hFFFF_FFFF, "rst_en1");
        rd_const(4, 32'hFFFF_FFFF, "rst_mode0");
        rd_const(2, 32'h0, "rst_pend0");
        rd_const(6, 32'h0, "rst_stat");

        // 2: single edge pulse, two-edge latency, ack clears, done idles
        src_i[5] = 1'b1; step();
        src_i[5] = 1'b0;
        chk("t2_req_one_edge", 64'(irq_req), 0);
        step();
        chk("t2_req_two_edges", 64'(irq_req), 1);
        chk("t2_id", 64'(irq_id), 5);
        rd_const(2, 32'h20, "t2_pend0_set");
        pulse_ack();
        chk("t2_req_after_ack", 64'(irq_req), 0);
        rd_const(2, 32'h0, "t2_pend0_clr");
        pulse_done();
        rd_const(6, 32'h0, "t2_stat_idle");

        // 3: priority across banks, back-to-back service
        src_i[3] = 1'b1; src_i[40] = 1'b1; step();
        src_i[3] = 1'b0; src_i[40] = 1'b0; step();
        chk("t3_id_first", 64'(irq_id), 3);
        pulse_ack();
        pulse_done();
        step();
        chk("t3_req_second", 64'(irq_req), 1);
        chk("t3_id_second", 64'(irq_id), 40);
        pulse_ack();
        pulse_done();

        // 4: disabled bank holds pending without requesting
        wr(1, 32'h0);
        src_i[33] = 1'b1; step();
        src_i[33] = 1'b0; step(); step();
        chk("t4_req_masked", 64'(irq_req), 0);
        rd_const(3, 32'h2, "t4_pend1");
        wr(1, 32'h2);
        step();
        chk("t4_req_enabled", 64'(irq_req), 1);
        chk("t4_id", 64'(irq_id), 33);
        pulse_ack();
        pulse_done();
        wr(1, 32'hFFFF_FFFF);

        // 5: level source ignores W1C and re-requests while held
        wr(4, 32'hFFFF_FF7F);
        src_i[7] = 1'b1; step(); step();
        chk("t5_req_level", 64'(irq_req), 1);
        chk("t5_id", 64'(irq_id), 7);
        wr(2, 32'h80);
        rd_const(2, 32'h80, "t5_pend_w1c_noeffect");
        pulse_ack();
        pulse_done();
        step();
        chk("t5_rereq", 64'(irq_req), 1);
        pulse_ack();
        src_i[7] = 1'b0;
        pulse_done();
        step();
        chk("t5_no_req_low", 64'(irq_req), 0);
        wr(4, 32'hFFFF_FFFF);

        // 6: software withdraw, then asynchronous reset mid-request
        src_i[9] = 1'b1; step();
        src_i[9] = 1'b0; step();
        chk("t6_id", 64'(irq_id), 9);
        wr(2, 32'h200);
        step();
        chk("t6_withdraw", 64'(irq_req), 0);
        src_i[9] = 1'b1; step();
        src_i[9] = 1'b0; step();
        chk("t6_req_again", 64'(irq_req), 1);
        #1 rst_n = 1'b0;
        model_reset();
        exp_irq.delete();
        exp_rd.delete();
        cs_en = 1'b1; rd_en = 1'b1; addr = 4'd2;
        #1;
        chk("t6_rst_req", 64'(irq_req), 0);
        chk("t6_rst_pend0", 64'(data_io), 0);
        cs_en = 1'b0; rd_en = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int j, op, a;
            irq_ack  = ($urandom_range(0, 3) == 0);
            irq_done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                j = $urandom_range(0, 63);
                src_i[j] = ~src_i[j];
            end
            op = $urandom_range(0, 7);
            a  = ($urandom_range(0, 15) == 0) ? 15 : $urandom_range(0, 7);
            cs_en = 1'b0; wt_en = 1'b0; rd_en = 1'b0; tb_drv_en = 1'b0;
            addr = 4'(a);
            if (op == 0) begin
                cs_en = 1'b1; wt_en = 1'b1; tb_drv_en = 1'b1;
                tb_drv = (a < 2) ? ($urandom | $urandom) : $urandom;
            end else if (op <= 2) begin
                cs_en = 1'b1; rd_en = 1'b1;
                e.name = "rnd_read"; e.val = model_read(a);
                exp_rd.push_back(e);
            end
            step();
        end
        cs_en = 1'b0; wt_en = 1'b0; rd_en = 1'b0; tb_drv_en = 1'b0;
        irq_ack = 1'b0; irq_done = 1'b0;
        step(); step();
        chk("irq_queue_drained", 64'(exp_irq.size()), 0);
        chk("rd_queue_drained", 64'(exp_rd.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
